tx_register_encoder: RTL and testbench

- Memory-mapped UART transmit path for the multicycle RISC-V core.
- The CPU writes a 32-bit Tx holding register and then pulses a start strobe.
- The block serializes the register's low byte as 8N1 on the tx line and reports busy/done status back to the CPU's read mux.
- It is the transmit-side counterpart of the UART Rx register path.

---
 rtl/tx_register_encoder_pkg.sv | 19 +
 rtl/tx_register_encoder_if.sv | 23 ++
 rtl/Reg_Param.sv | 17 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/tx_register_encoder.sv | 112 +++++++++++
 tb/tb_tx_register_encoder.sv | 283 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/tx_register_encoder_pkg.sv
// Shared definitions for the UART transmit register path: FSM encoding and 8N1 frame constants.
package tx_register_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;
  localparam int REG_W      = 32;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/tx_register_encoder_if.sv
// CPU-side bus of the UART transmit register: holding-register write, start strobe and status.
interface tx_register_encoder_if;
  // reg_enable writes Reg_UART_Tx into the holding register on any edge. tx_start is a
  // one-cycle request; it is taken only while tx_busy is low (including the tx_done cycle),
  // otherwise it is dropped. tx_busy rises on the edge after an accepted tx_start.
  logic        reg_enable;
  logic [31:0] Reg_UART_Tx;
  logic        tx_start;
  logic [31:0] UART_Tx_Reg;
  logic        tx;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output reg_enable, Reg_UART_Tx, tx_start,
    input  UART_Tx_Reg, tx, tx_busy, tx_done
  );

  modport slave (
    input  reg_enable, Reg_UART_Tx, tx_start,
    output UART_Tx_Reg, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/Reg_Param.sv
// Parameterized enable register with asynchronous active-low clear.
module Reg_Param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last clock of each CLKS_PER_BIT period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                           cnt <= cnt + CNT_W'(1);
  end

  // Suppressed while cleared so a held-clear counter never signals a boundary.
  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/tx_register_encoder.sv
// Memory-mapped UART transmitter: 32-bit holding register plus an 8N1 serializer of its low byte.
module tx_register_encoder
  import tx_register_encoder_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  tx_register_encoder_if.slave  bus,
  output tx_state_e             dbg_state
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int IDX_W        = $clog2(DATA_BITS);

  tx_state_e        state, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             tick;
  logic             clear;
  logic [REG_W-1:0] hold_q;

  Reg_Param #(.WIDTH(REG_W)) u_hold (
    .clk (clk),
    .rst (rst),
    .en  (bus.reg_enable),
    .d   (bus.Reg_UART_Tx),
    .q   (hold_q)
  );

  // Held clear through IDLE so the first START cycle always sees a zero count.
  assign clear = (state == IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    state_d = state;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    case (state)
      IDLE: begin
        if (bus.tx_start) begin
          state_d = START;
          idx_d   = '0;
          shift_d = bus.reg_enable ? bus.Reg_UART_Tx[7:0] : hold_q[7:0];
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = STOP;
          else                                idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is decoded from the next state so tx itself is a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign bus.UART_Tx_Reg = hold_q;
  assign bus.tx          = tx_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_tx_register_encoder.sv
// Bench for tx_register_encoder: frame-level model, line receiver, vector table and corner sequences.
module tb_tx_register_encoder;
  import tx_register_encoder_pkg::*;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD      = 1;
  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_register_encoder_if bus();
  tx_state_e dbg_state;

  tx_register_encoder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is just a position 0..FRAME_CYC-1 in a fixed 10-bit pattern; -1 means the line is free.
  logic [31:0] m_reg  = '0;
  int          m_pos  = -1;
  logic [7:0]  m_byte = '0;
  logic        m_done = 1'b0;
  logic [7:0]  m_fwd_byte;
  logic [7:0]  exp_q[$];

  assign m_fwd_byte = bus.reg_enable ? bus.Reg_UART_Tx[7:0] : m_reg[7:0];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reg  <= '0;
      m_pos  <= -1;
      m_done <= 1'b0;
      exp_q.delete();
    end else begin
      if (m_pos >= 0) begin
        m_pos  <= (m_pos == FRAME_CYC - 1) ? -1 : m_pos + 1;
        m_done <= (m_pos == FRAME_CYC - 1);
      end else begin
        m_done <= 1'b0;
        if (bus.tx_start) begin
          m_pos  <= 0;
          m_byte <= m_fwd_byte;
          exp_q.push_back(m_fwd_byte);
        end
      end
      if (bus.reg_enable) m_reg <= bus.Reg_UART_Tx;
    end
  end

  function automatic logic model_tx(input int pos, input logic [7:0] b);
    int k;
    if (pos < 0) return 1'b1;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k == FRAME_BITS - 1) return 1'b1;
    return b[k-1];
  endfunction

  always @(negedge clk) begin
    chk("tx_line", {31'd0, bus.tx}, {31'd0, model_tx(m_pos, m_byte)});
    chk("tx_busy", {31'd0, bus.tx_busy}, {31'd0, (m_pos >= 0)});
    chk("tx_done", {31'd0, bus.tx_done}, {31'd0, m_done});
    chk("hold_reg", bus.UART_Tx_Reg, m_reg);
  end

  // ---------------- line receiver / scoreboard ----------------
  int         rx_pos    = -1;
  logic [7:0] rx_byte   = '0;
  logic [7:0] rx_last   = '0;
  int         rx_frames = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      rx_pos <= -1;
    end else if (rx_pos < 0) begin
      if (bus.tx === 1'b0) rx_pos <= 1;
    end else begin
      rx_pos <= rx_pos + 1;
      if (rx_pos % CPB == CPB / 2) begin
        if (rx_pos / CPB == 0) begin
          chk("rx_start_bit", {31'd0, bus.tx}, 32'd0);
        end else if (rx_pos / CPB <= DATA_BITS) begin
          rx_byte[rx_pos/CPB - 1] <= bus.tx;
        end else begin
          chk("rx_stop_bit", {31'd0, bus.tx}, 32'd1);
          rx_last   <= rx_byte;
          rx_frames <= rx_frames + 1;
          rx_pos    <= -1;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rx_unexpected_frame: actual %h required none", rx_byte);
          end else if (rx_byte !== exp_q[0]) begin
            n_err++;
            $display("FAIL rx_byte: actual %h required %h", rx_byte, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic step(input logic en, input logic [31:0] d, input logic st);
    bus.reg_enable  = en;
    bus.Reg_UART_Tx = d;
    bus.tx_start    = st;
    @(negedge clk);
    bus.reg_enable  = 1'b0;
    bus.tx_start    = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < FRAME_CYC + 10; i++) begin
      if (bus.tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.tx_busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    chk("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] wdata;
    logic        fwd;
    logic [7:0]  exp_byte;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int busy_cnt;
    int f0;
    logic [31:0] rd;
    bus.reg_enable  = 1'b0;
    bus.Reg_UART_Tx = '0;
    bus.tx_start    = 1'b0;

    vecs[0] = '{32'h0000_00A5, 1'b0, 8'hA5, 32'h0000_00A5};
    vecs[1] = '{32'h0000_003C, 1'b1, 8'h3C, 32'h0000_003C};
    vecs[2] = '{32'h1234_5600, 1'b1, 8'h00, 32'h1234_5600};
    vecs[3] = '{32'hDEAD_BEFF, 1'b0, 8'hFF, 32'hDEAD_BEFF};
    vecs[4] = '{32'h0000_0080, 1'b0, 8'h80, 32'h0000_0080};

    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    chk("por_tx", {31'd0, bus.tx}, 32'd1);
    chk("por_busy", {31'd0, bus.tx_busy}, 32'd0);
    chk("por_done", {31'd0, bus.tx_done}, 32'd0);
    chk("por_reg", bus.UART_Tx_Reg, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);

    // Vector table: plain and forwarded starts.
    for (int v = 0; v < 5; v++) begin
      f0 = rx_frames;
      if (vecs[v].fwd) begin
        step(1'b1, vecs[v].wdata, 1'b1);
      end else begin
        step(1'b1, vecs[v].wdata, 1'b0);
        step(1'b0, 32'h0, 1'b1);
      end
      wait_done(busy_cnt);
      chk($sformatf("vec%0d_busy_cycles", v), busy_cnt, FRAME_CYC);
      chk($sformatf("vec%0d_byte", v), {24'd0, rx_last}, {24'd0, vecs[v].exp_byte});
      chk($sformatf("vec%0d_frames", v), rx_frames, f0 + 1);
      chk($sformatf("vec%0d_reg", v), bus.UART_Tx_Reg, vecs[v].exp_reg);
      cyc(1);
      chk($sformatf("vec%0d_done_width", v), {31'd0, bus.tx_done}, 32'd0);
      cyc(3);
    end

    // Write during frame leaves the byte on the line alone.
    step(1'b1, 32'h55, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    cyc(39);
    step(1'b1, 32'hFF, 1'b0);
    wait_done(busy_cnt);
    chk("wdf_byte", {24'd0, rx_last}, 32'h55);
    chk("wdf_reg", bus.UART_Tx_Reg, 32'hFF);
    cyc(3);

    // Ignored start while busy, then back-to-back start in the tx_done cycle.
    f0 = rx_frames;
    step(1'b1, 32'h0F, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    cyc(69);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h96, 1'b0);
    wait_done(busy_cnt);
    chk("b2b_first_byte", {24'd0, rx_last}, 32'h0F);
    step(1'b0, 32'h0, 1'b1);
    chk("b2b_start_tx", {31'd0, bus.tx}, 32'd0);
    chk("b2b_start_busy", {31'd0, bus.tx_busy}, 32'd1);
    wait_done(busy_cnt);
    chk("b2b_second_byte", {24'd0, rx_last}, 32'h96);
    cyc(20);
    chk("b2b_frames", rx_frames, f0 + 2);
    chk("b2b_idle_busy", {31'd0, bus.tx_busy}, 32'd0);

    // Reset in the middle of DATA (a zero bit is on the line).
    step(1'b1, 32'hC3, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    cyc(49);
    chk("mid_pre_tx", {31'd0, bus.tx}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, bus.tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus.tx_busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.tx_done}, 32'd0);
    chk("mid_rst_reg", bus.UART_Tx_Reg, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    step(1'b1, 32'h5A, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    wait_done(busy_cnt);
    chk("post_rst_busy_cycles", busy_cnt, FRAME_CYC);
    chk("post_rst_byte", {24'd0, rx_last}, 32'h5A);
    cyc(2);

    // Randomized traffic against the model.
    for (int r = 0; r < 20; r++) begin
      rd = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, rd, 1'b1);
      end else begin
        step(1'b1, rd, 1'b0);
        step(1'b0, 32'h0, 1'b1);
      end
      cyc($urandom_range(0, 130));
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      wait_done(busy_cnt);
      if ($urandom_range(0, 1) == 1) begin
        step(1'($urandom_range(0, 1)), $urandom, 1'b1);
        wait_done(busy_cnt);
      end
      cyc($urandom_range(1, 4));
    end

    cyc(5);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
